ow_sensor_scheduler: RTL and testbench

OW_SENSOR_SCHEDULER -- requirements
Module: ow_sensor_scheduler

---
 rtl/ow_sensor_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ow_sensor_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ow_sensor_scheduler.sv
// Round-robin DS18B20 poller: drives a 1-Wire byte engine through match-ROM,
// convert, wait, read-scratchpad and CRC check, then reports one result per sensor.
module ow_sensor_scheduler #(
  parameter int N_SENSORS   = 4,
  parameter int CONV_CYCLES = 37_500_000,
  parameter int IDX_W       = 3
) (
  input  logic                     local_clk,
  input  logic                     local_rst_n,
  input  logic                     enable,
  input  logic [64*N_SENSORS-1:0]  rom_codes,
  output logic [1:0]               op_code,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [7:0]               op_wdata,
  input  logic                     op_done,
  input  logic [7:0]               op_rdata,
  input  logic                     op_presence,
  output logic [15:0]              temp_data,
  output logic [IDX_W-1:0]         temp_idx,
  output logic                     temp_valid,
  output logic                     temp_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int OFF_W = $clog2(64 * N_SENSORS);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_MATCH1, S_ROM1, S_CONV, S_WAIT, S_RST2,
    S_MATCH2, S_ROM2, S_RDCMD, S_READ, S_CHECK, S_NEXT
  } state_t;

  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_byte;
  logic [7:0]        r_crc, r_b0, r_b1;
  logic              r_err;
  logic              r_out;
  logic              r_op_valid;
  logic [1:0]        r_op_code;
  logic [7:0]        r_op_wdata;

  logic              w_done, w_last, w_step, w_op_req, w_issue;
  logic [1:0]        w_code;
  logic [7:0]        w_wdata, w_rom_byte;
  logic [OFF_W-1:0]  w_rom_off;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    // NOTE: blocking '=' is correct inside functions and always_comb; only
    // clocked state uses '<='.
    c = crc;
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 8'h8C : 8'h00);
    return c;
  endfunction

  // Only a completion for an accepted request counts; strays are dropped here.
  assign w_done     = op_done & r_out;
  assign w_step     = w_done & w_last;
  assign w_issue    = w_op_req & ~r_op_valid & ~r_out;
  assign w_rom_off  = OFF_W'({r_idx, r_byte[2:0], 3'b000});
  assign w_rom_byte = rom_codes[w_rom_off +: 8];

  always_comb begin
    w_last = 1'b1;
    case (r_state)
      S_ROM1, S_ROM2: w_last = (r_byte == 4'd7);
      S_READ:         w_last = (r_byte == 4'd8);
      default:        w_last = 1'b1;
    endcase
  end

  always_ff @(posedge local_clk or negedge local_rst_n) begin
    if (!local_rst_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_RST1;
      S_RST1:   if (w_done) w_next = op_presence ? S_MATCH1 : S_CHECK;
      S_MATCH1: if (w_step) w_next = S_ROM1;
      S_ROM1:   if (w_step) w_next = S_CONV;
      S_CONV:   if (w_step) w_next = S_WAIT;
      S_WAIT:   if (r_cnt == CNT_W'(CONV_CYCLES - 1)) w_next = S_RST2;
      S_RST2:   if (w_done) w_next = op_presence ? S_MATCH2 : S_CHECK;
      S_MATCH2: if (w_step) w_next = S_ROM2;
      S_ROM2:   if (w_step) w_next = S_RDCMD;
      S_RDCMD:  if (w_step) w_next = S_READ;
      S_READ:   if (w_step) w_next = S_CHECK;
      S_CHECK:  w_next = S_NEXT;
      S_NEXT:   w_next = enable ? S_RST1 : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_op_req   = 1'b0;
    w_code     = OP_RESET;
    w_wdata    = 8'h00;
    busy       = (r_state != S_IDLE);
    temp_valid = (r_state == S_CHECK);
    temp_err   = 1'b0;
    temp_idx   = '0;
    temp_data  = 16'h0000;
    case (r_state)
      S_RST1, S_RST2:     w_op_req = 1'b1;
      S_MATCH1, S_MATCH2: begin w_op_req = 1'b1; w_code = OP_WRITE; w_wdata = 8'h55; end
      S_ROM1, S_ROM2:     begin w_op_req = 1'b1; w_code = OP_WRITE; w_wdata = w_rom_byte; end
      S_CONV:             begin w_op_req = 1'b1; w_code = OP_WRITE; w_wdata = 8'h44; end
      S_RDCMD:            begin w_op_req = 1'b1; w_code = OP_WRITE; w_wdata = 8'hBE; end
      S_READ:             begin w_op_req = 1'b1; w_code = OP_READ; end
      S_CHECK: begin
        temp_err  = r_err;
        temp_idx  = r_idx;
        temp_data = r_err ? 16'h0000 : {r_b1, r_b0};
      end
      default: ;
    endcase
  end

  assign op_valid = r_op_valid;
  assign op_code  = r_op_code;
  assign op_wdata = r_op_wdata;

  always_ff @(posedge local_clk or negedge local_rst_n) begin
    if (!local_rst_n) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_crc      <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_err      <= 1'b0;
      r_out      <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_code  <= OP_RESET;
      r_op_wdata <= '0;
    end else begin
      if (w_issue) begin
        r_op_valid <= 1'b1;
        r_op_code  <= w_code;
        r_op_wdata <= w_wdata;
      end else if (r_op_valid && op_ready) begin
        r_op_valid <= 1'b0;
        r_out      <= 1'b1;
      end
      if (w_done) begin
        r_out  <= 1'b0;
        r_byte <= w_last ? 4'd0 : r_byte + 4'd1;
      end

      r_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + 1'b1 : '0;

      if ((r_state == S_RST1 || r_state == S_RST2) && w_done && !op_presence)
        r_err <= 1'b1;

      if (r_state == S_READ && w_done) begin
        if (r_byte == 4'd0) r_b0 <= op_rdata;
        if (r_byte == 4'd1) r_b1 <= op_rdata;
        if (r_byte < 4'd8)  r_crc <= crc8_byte(r_crc, op_rdata);
        else if (op_rdata != r_crc) r_err <= 1'b1;
      end

      if (r_state == S_NEXT) begin
        r_idx <= (r_idx == IDX_W'(N_SENSORS - 1)) ? '0 : r_idx + 1'b1;
        r_err <= 1'b0;
        r_crc <= '0;
        r_b0  <= '0;
        r_b1  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ow_sensor_scheduler.sv
// Bench for ow_sensor_scheduler: a byte-engine responder with back-pressure,
// directed vectors, randomized sensors against a result/op-sequence model.
module tb_ow_sensor_scheduler;
  localparam int NS = 2;
  localparam int CC = 100;

  logic              local_clk = 1'b0;
  logic              local_rst_n = 1'b1;
  logic              enable = 1'b0;
  logic [64*NS-1:0]  rom_codes = '0;
  logic [1:0]        op_code;
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_wdata;
  logic              op_done;
  logic [7:0]        op_rdata;
  logic              op_presence;
  logic [15:0]       temp_data;
  logic              temp_idx;
  logic              temp_valid;
  logic              temp_err;
  logic              busy;

  ow_sensor_scheduler #(.N_SENSORS(NS), .CONV_CYCLES(CC), .IDX_W(1)) dut (
    .local_clk(local_clk), .local_rst_n(local_rst_n), .enable(enable),
    .rom_codes(rom_codes), .op_code(op_code), .op_valid(op_valid),
    .op_ready(op_ready), .op_wdata(op_wdata), .op_done(op_done),
    .op_rdata(op_rdata), .op_presence(op_presence), .temp_data(temp_data),
    .temp_idx(temp_idx), .temp_valid(temp_valid), .temp_err(temp_err), .busy(busy)
  );

  always #5 local_clk = ~local_clk;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] wdata;
  } op_t;

  typedef struct packed {
    logic        pres;
    logic [71:0] bytes;
    logic [2:0]  stall;
    logic        inj;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  op_t         log_q[$];
  int          valid_cyc[$];
  int          done_cyc[$];
  logic [7:0]  rom_b [NS][8];
  logic        scen_pres = 1'b1;
  logic [71:0] scen_bytes = '0;
  int          scen_stall = 0;
  logic        scen_inj = 1'b0;
  logic        force_done = 1'b0;
  int          exp_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dallas CRC-8 over the 64-bit message viewed as one LSB-first bit stream.
  function automatic logic [7:0] model_crc(input logic [71:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      logic fb;
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 8'h8C;
    end
    return r;
  endfunction

  function automatic logic [16:0] model_result(input logic pres, input logic [71:0] b);
    if (!pres) return {1'b1, 16'h0000};
    if (model_crc(b) != b[71:64]) return {1'b1, 16'h0000};
    return {1'b0, b[15:0]};
  endfunction

  function automatic op_t exp_op(input int k, input int idx);
    op_t e;
    e = {2'd0, 8'h00};
    if (k == 0 || k == 11)          e = {2'd0, 8'h00};
    else if (k == 1 || k == 12)     e = {2'd1, 8'h55};
    else if (k >= 2 && k <= 9)      e = {2'd1, rom_b[idx][k-2]};
    else if (k == 10)               e = {2'd1, 8'h44};
    else if (k >= 13 && k <= 20)    e = {2'd1, rom_b[idx][k-13]};
    else if (k == 21)               e = {2'd1, 8'hBE};
    else                            e = {2'd2, 8'h00};
    return e;
  endfunction

  task automatic randomize_rom();
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 8; j++) begin
        rom_b[k][j] = 8'($urandom);
        rom_codes[64*k + 8*j +: 8] = rom_b[k][j];
      end
  endtask

  // Byte-engine responder: decides everything on the falling edge.
  initial begin
    logic       outstanding, armed;
    int         done_cnt, stall_left, rd_cnt, cyc;
    logic [1:0] cur_code, seen_code;
    logic [7:0] seen_wdata;
    outstanding = 0; armed = 0; done_cnt = 0; stall_left = 0; rd_cnt = 0; cyc = 0;
    cur_code = 0; seen_code = 0; seen_wdata = 0;
    op_ready = 0; op_done = 0; op_rdata = 0; op_presence = 0;
    forever begin
      @(negedge local_clk);
      cyc++;
      op_done = force_done;
      if (!local_rst_n) begin
        outstanding = 0; armed = 0; rd_cnt = 0; op_ready = 0;
      end else if (outstanding) begin
        if (done_cnt == 0) begin
          op_done = 1'b1;
          outstanding = 0;
          done_cyc.push_back(cyc);
          if (cur_code == 2'd0) begin
            op_presence = scen_pres;
            rd_cnt = 0;
          end else if (cur_code == 2'd2) begin
            op_rdata = scen_bytes[8*rd_cnt +: 8];
            rd_cnt++;
          end
        end else done_cnt--;
      end else if (op_valid) begin
        if (!armed) begin
          armed = 1; stall_left = scen_stall;
          seen_code = op_code; seen_wdata = op_wdata;
          valid_cyc.push_back(cyc);
        end else begin
          check("stall_code_stable", 32'(op_code), 32'(seen_code));
          check("stall_wdata_stable", 32'(op_wdata), 32'(seen_wdata));
        end
        if (stall_left > 0) begin
          op_ready = 1'b0;
          stall_left--;
          op_done = op_done | scen_inj;
        end else begin
          op_ready = 1'b1;
          armed = 0;
          outstanding = 1;
          done_cnt = $urandom_range(0, 2);
          log_q.push_back({seen_code, seen_wdata});
          cur_code = seen_code;
        end
      end else begin
        if (armed) check("op_valid_held", 32'(op_valid), 32'd1);
        armed = 0;
        op_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic start_sensor(input logic pres, input logic [71:0] bytes,
                              input int stall, input logic inj);
    scen_pres = pres; scen_bytes = bytes; scen_stall = stall; scen_inj = inj;
    log_q.delete(); valid_cyc.delete(); done_cyc.delete();
  endtask

  task automatic wait_log(input int n);
    for (int t = 0; t < 3000 && log_q.size() < n; t++) @(negedge local_clk);
    check("log_wait_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic finish_sensor(input string tag, input logic [16:0] exp_res);
    logic got;
    int   first_bad, n_exp, n_cmp;
    op_t  e;
    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge local_clk);
      if (temp_valid) got = 1;
    end
    check({tag, "_result_timeout"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_idx"}, 32'(temp_idx), 32'(exp_idx));
    check({tag, "_err"}, 32'(temp_err), 32'(exp_res[16]));
    check({tag, "_data"}, 32'(temp_data), 32'(exp_res[15:0]));
    n_exp = scen_pres ? 31 : 1;
    check({tag, "_op_count"}, 32'(log_q.size()), 32'(n_exp));
    n_cmp = (log_q.size() < n_exp) ? log_q.size() : n_exp;
    first_bad = -1;
    for (int k = 0; k < n_cmp; k++) begin
      e = exp_op(k, exp_idx);
      if (first_bad < 0 && (log_q[k].code !== e.code ||
          (e.code == 2'd1 && log_q[k].wdata !== e.wdata)))
        first_bad = k;
    end
    check({tag, "_op_seq_first_bad"}, 32'(first_bad), 32'hFFFF_FFFF);
    @(negedge local_clk);
    check({tag, "_strobe_one_cycle"}, 32'(temp_valid), 32'd0);
    exp_idx = (exp_idx + 1) % NS;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [71:0] GOOD = 72'h1C_10_0C_FF_7F_46_4B_05_50;
  localparam logic [71:0] BADC = 72'h1D_10_0C_FF_7F_46_4B_05_50;

  initial begin
    vec_t        vecs[5];
    logic [71:0] b;
    logic        pres, seen;
    logic [7:0]  c;

    //          pres  bytes  stall inj  err   data
    vecs[0] = {1'b1, GOOD,  3'd0, 1'b0, 1'b0, 16'h0550};
    vecs[1] = {1'b0, GOOD,  3'd0, 1'b0, 1'b1, 16'h0000};
    vecs[2] = {1'b1, BADC,  3'd0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = {1'b1, 72'h0, 3'd5, 1'b0, 1'b0, 16'h0000};
    vecs[4] = {1'b1, GOOD,  3'd3, 1'b1, 1'b0, 16'h0550};

    randomize_rom();
    #2 local_rst_n = 1'b0;
    #1;
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_op_code", 32'(op_code), 0);
    check("rst_op_wdata", 32'(op_wdata), 0);
    check("rst_temp_data", 32'(temp_data), 0);
    check("rst_temp_idx", 32'(temp_idx), 0);
    check("rst_temp_valid", 32'(temp_valid), 0);
    check("rst_temp_err", 32'(temp_err), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge local_clk);
    local_rst_n = 1'b1;

    // Idle with a stray completion: nothing may start or report.
    force_done = 1'b1;
    @(negedge local_clk);
    @(negedge local_clk);
    force_done = 1'b0;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge local_clk);
      seen = seen | busy | op_valid | temp_valid;
    end
    check("idle_stray_done_ignored", 32'(seen), 0);

    for (int i = 0; i < 5; i++) begin
      start_sensor(vecs[i].pres, vecs[i].bytes, int'(vecs[i].stall), vecs[i].inj);
      if (i == 0) enable = 1'b1;
      finish_sensor($sformatf("vec%0d", i), {vecs[i].exp_err, vecs[i].exp_data});
      // CONV done -> one edge into WAIT, CC clocks of WAIT, one edge to register RESET.
      if (i == 0) check("wait_gap", 32'(valid_cyc[11] - done_cyc[10]), 32'(CC + 2));
    end

    for (int i = 0; i < 30; i++) begin
      randomize_rom();
      pres = ($urandom_range(0, 9) != 0);
      for (int j = 0; j < 8; j++) b[8*j +: 8] = 8'($urandom);
      c = model_crc(b);
      b[71:64] = ($urandom_range(0, 2) != 0) ? c : c ^ 8'($urandom_range(1, 255));
      start_sensor(pres, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      finish_sensor($sformatf("rnd%0d", i), model_result(pres, b));
    end

    // enable dropped during WAIT: the sensor still completes, then IDLE.
    start_sensor(1'b1, GOOD, 0, 1'b0);
    wait_log(11);
    repeat (5) @(negedge local_clk);
    enable = 1'b0;
    finish_sensor("en_drop", model_result(1'b1, GOOD));
    repeat (2) @(negedge local_clk);
    check("en_drop_busy_low", 32'(busy), 0);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge local_clk);
      seen = seen | busy | op_valid;
    end
    check("en_drop_stays_idle", 32'(seen), 0);

    // Reset pulse during READ.
    enable = 1'b1;
    start_sensor(1'b1, GOOD, 0, 1'b0);
    wait_log(24);
    local_rst_n = 1'b0;
    #1;
    check("mid_rst_op_valid", 32'(op_valid), 0);
    check("mid_rst_op_code", 32'(op_code), 0);
    check("mid_rst_op_wdata", 32'(op_wdata), 0);
    check("mid_rst_temp_data", 32'(temp_data), 0);
    check("mid_rst_temp_idx", 32'(temp_idx), 0);
    check("mid_rst_temp_valid", 32'(temp_valid), 0);
    check("mid_rst_temp_err", 32'(temp_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge local_clk);
    start_sensor(1'b1, GOOD, 0, 1'b0);
    exp_idx = 0;
    local_rst_n = 1'b1;
    force_done = 1'b1;
    @(negedge local_clk);
    @(negedge local_clk);
    force_done = 1'b0;
    finish_sensor("post_rst", model_result(1'b1, GOOD));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
